// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with byte-wide RX and TX FIFOs on the system side.
// SPI pins are asynchronous to clk and are oversampled (clk >= 8x SCK).
// Optional sticky overrun/underrun status is compiled in with SPI_TARGET_STATUS_EN.

module spi_target #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_FILL  = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       tx_wr,
  input  logic [7:0] tx_din,
  output logic       tx_full,
  input  logic       rx_rd,
  output logic [7:0] rx_dout,
  output logic       rx_data_avail,
  output logic       busy
`ifdef SPI_TARGET_STATUS_EN
  ,
  input  logic       status_clr,
  output logic       overrun,
  output logic       underrun
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Synchronizer and edge-detect stages
  logic r_sckMeta, r_sckSync, r_sckPrev;
  logic r_csMeta,  r_csSync,  r_csPrev;
  logic r_mosiMeta, r_mosiSync;

  logic w_sckRise, w_sckFall, w_csFall, w_csRise;

  // Frame state
  state_t r_state, w_nextState;
  logic [7:0] r_txShift;
  logic [7:0] r_rxShift;
  logic [2:0] r_bitCnt;

  logic w_txLoad, w_txShiftEn, w_rxSample, w_cntClr;

  // TX FIFO
  logic [7:0] r_txMem [FIFO_DEPTH];
  logic [AW:0] r_txWrPtr, r_txRdPtr;
  logic w_txEmpty, w_txFull, w_txPush, w_txPop;
  logic [7:0] w_txHead;

  // RX FIFO
  logic [7:0] r_rxMem [FIFO_DEPTH];
  logic [AW:0] r_rxWrPtr, r_rxRdPtr;
  logic w_rxEmpty, w_rxFull, w_rxPushReq, w_rxPush, w_rxPop;
  logic [7:0] w_rxByte;

  // Bring the three SPI pins into the clk domain; reset to the deselected bus state
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_sckMeta  <= 1'b0;
      r_sckSync  <= 1'b0;
      r_sckPrev  <= 1'b0;
      r_csMeta   <= 1'b1;
      r_csSync   <= 1'b1;
      r_csPrev   <= 1'b1;
      r_mosiMeta <= 1'b0;
      r_mosiSync <= 1'b0;
    end else begin
      r_sckMeta  <= spi_sck;
      r_sckSync  <= r_sckMeta;
      r_sckPrev  <= r_sckSync;
      r_csMeta   <= spi_cs;
      r_csSync   <= r_csMeta;
      r_csPrev   <= r_csSync;
      r_mosiMeta <= spi_mosi;
      r_mosiSync <= r_mosiMeta;
    end
  end

  assign w_sckRise = r_sckSync & ~r_sckPrev;
  assign w_sckFall = ~r_sckSync & r_sckPrev;
  assign w_csFall  = ~r_csSync & r_csPrev;
  assign w_csRise  = r_csSync & ~r_csPrev;

  assign busy = ~r_csSync;

  // FIFO flags: pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_txEmpty = (r_txWrPtr == r_txRdPtr);
  assign w_txFull  = (r_txWrPtr[AW] != r_txRdPtr[AW]) &&
                     (r_txWrPtr[AW-1:0] == r_txRdPtr[AW-1:0]);
  assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
  assign w_rxFull  = (r_rxWrPtr[AW] != r_rxRdPtr[AW]) &&
                     (r_rxWrPtr[AW-1:0] == r_rxRdPtr[AW-1:0]);

  assign w_txHead = r_txMem[r_txRdPtr[AW-1:0]];

  assign tx_full       = w_txFull;
  assign rx_data_avail = ~w_rxEmpty;
  assign rx_dout       = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRdPtr[AW-1:0]];

  // A push is accepted when there is room, or when a pop frees a slot in the same cycle
  assign w_txPop  = w_txLoad & ~w_txEmpty;
  assign w_txPush = tx_wr & (~w_txFull | w_txPop);

  assign w_rxByte    = {r_rxShift[6:0], r_mosiSync};
  assign w_rxPushReq = w_rxSample & (r_bitCnt == 3'd7);
  assign w_rxPop     = rx_rd & ~w_rxEmpty;
  assign w_rxPush    = w_rxPushReq & (~w_rxFull | w_rxPop);

  // Frame state register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-cycle datapath strobes; a chip-select release aborts everything
  always_comb begin
    w_nextState = r_state;
    w_txLoad    = 1'b0;
    w_txShiftEn = 1'b0;
    w_rxSample  = 1'b0;
    w_cntClr    = 1'b0;
    if (w_csRise) begin
      w_nextState = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_csFall) begin
            w_nextState = LOAD;
          end
        end
        LOAD: begin
          w_txLoad    = 1'b1;
          w_cntClr    = 1'b1;
          w_nextState = SHIFT;
        end
        SHIFT: begin
          if (w_sckRise) begin
            w_rxSample = 1'b1;
          end
          if (w_sckFall) begin
            if (r_bitCnt == 3'd0) begin
              w_txLoad = 1'b1;
            end else begin
              w_txShiftEn = 1'b1;
            end
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Shift registers and bit counter; the counter reaching 0 on a falling edge marks a byte boundary
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_txShift <= 8'h00;
      r_rxShift <= 8'h00;
      r_bitCnt  <= 3'd0;
    end else begin
      if (w_txLoad) begin
        r_txShift <= w_txEmpty ? IDLE_FILL : w_txHead;
      end else if (w_txShiftEn) begin
        r_txShift <= {r_txShift[6:0], 1'b0};
      end
      if (w_cntClr) begin
        r_bitCnt <= 3'd0;
      end else if (w_rxSample) begin
        r_rxShift <= w_rxByte;
        r_bitCnt  <= r_bitCnt + 3'd1;
      end
    end
  end

  assign spi_miso = ((r_state == LOAD) || (r_state == SHIFT)) ? r_txShift[7] : 1'b0;

  // FIFO pointer bookkeeping
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_txWrPtr <= '0;
      r_txRdPtr <= '0;
      r_rxWrPtr <= '0;
      r_rxRdPtr <= '0;
    end else begin
      if (w_txPush) begin
        r_txWrPtr <= r_txWrPtr + PTR_ONE;
      end
      if (w_txPop) begin
        r_txRdPtr <= r_txRdPtr + PTR_ONE;
      end
      if (w_rxPush) begin
        r_rxWrPtr <= r_rxWrPtr + PTR_ONE;
      end
      if (w_rxPop) begin
        r_rxRdPtr <= r_rxRdPtr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_txPush) begin
      r_txMem[r_txWrPtr[AW-1:0]] <= tx_din;
    end
    if (w_rxPush) begin
      r_rxMem[r_rxWrPtr[AW-1:0]] <= w_rxByte;
    end
  end

`ifdef SPI_TARGET_STATUS_EN
  logic w_rxDrop, w_underrunEvt;

  assign w_rxDrop      = w_rxPushReq & ~w_rxPush;
  assign w_underrunEvt = w_txLoad & w_txEmpty;

  // Sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (w_rxDrop) begin
        overrun <= 1'b1;
      end else if (status_clr) begin
        overrun <= 1'b0;
      end
      if (w_underrunEvt) begin
        underrun <= 1'b1;
      end else if (status_clr) begin
        underrun <= 1'b0;
      end
    end
  end
`else
  // Dropped RX bytes and idle-fill loads go unreported in this build.
`endif

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives SPI mode-0 frames against spi_target and checks them against
// a queue-based model of the TX/RX FIFOs and byte-boundary reload behaviour.

module tb_spi_target;

  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] IDLE_FILL  = 8'hFF;

  logic       clk;
  logic       Rst;
  logic       spi_sck;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       tx_full;
  logic       rx_rd;
  logic [7:0] rx_dout;
  logic       rx_data_avail;
  logic       busy;
`ifdef SPI_TARGET_STATUS_EN
  logic       status_clr;
  logic       overrun;
  logic       underrun;
`endif

  spi_target #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDLE_FILL (IDLE_FILL)
  ) dut (
    .clk          (clk),
    .Rst          (Rst),
    .spi_sck      (spi_sck),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .tx_wr        (tx_wr),
    .tx_din       (tx_din),
    .tx_full      (tx_full),
    .rx_rd        (rx_rd),
    .rx_dout      (rx_dout),
    .rx_data_avail(rx_data_avail),
    .busy         (busy)
`ifdef SPI_TARGET_STATUS_EN
    ,
    .status_clr   (status_clr),
    .overrun      (overrun),
    .underrun     (underrun)
`endif
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  logic [7:0] txModel[$];
  logic [7:0] rxModel[$];
  logic       overrunModel = 1'b0;
  logic       underrunModel = 1'b0;

  // Frame stimulus and captured results
  logic [7:0] mosiQ[$];
  logic [7:0] misoQ[$];
  logic       misoEarly;
  logic       availFirst;
  logic       busyMid;
  logic       holdWr = 1'b0;
  logic [7:0] holdByte = 8'h00;
  logic       holdFull;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelTxPush(input logic [7:0] b);
    if (txModel.size() < FIFO_DEPTH) txModel.push_back(b);
  endfunction

  function automatic logic [7:0] modelLoad();
    if (txModel.size() > 0) return txModel.pop_front();
    underrunModel = 1'b1;
    return IDLE_FILL;
  endfunction

  function automatic void modelRxPush(input logic [7:0] b);
    if (rxModel.size() < FIFO_DEPTH) rxModel.push_back(b);
    else overrunModel = 1'b1;
  endfunction

  task automatic checkStatus();
`ifdef SPI_TARGET_STATUS_EN
    checkOutput("overrun", overrun, overrunModel);
    checkOutput("underrun", underrun, underrunModel);
`endif
  endtask

  task automatic clearStatus();
`ifdef SPI_TARGET_STATUS_EN
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
`endif
    overrunModel  = 1'b0;
    underrunModel = 1'b0;
  endtask

  task automatic pushTx(input logic [7:0] b);
    @(negedge clk);
    tx_wr  = 1'b1;
    tx_din = b;
    @(negedge clk);
    tx_wr  = 1'b0;
    modelTxPush(b);
  endtask

  task automatic readRx(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("rxAvailHead", rx_data_avail, 1'b1);
      checkOutput("rxDout", rx_dout, rxModel[0]);
      @(negedge clk);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      void'(rxModel.pop_front());
    end
  endtask

  // Initiator side of one chip-select frame of nBits bits, MSB first, 16 clk per SCK period
  task automatic applyStimulus(input int nBits);
    logic [7:0] shiftIn;
    logic [7:0] cur;
    shiftIn = 8'h00;
    misoQ.delete();
    @(negedge clk);
    spi_cs = 1'b0;
    if (holdWr) begin
      tx_wr  = 1'b1;
      tx_din = holdByte;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) misoEarly = spi_miso;
      if (c == 6) begin
        tx_wr    = 1'b0;
        holdFull = tx_full;
      end
      if (c == 8) busyMid = busy;
    end
    for (int i = 0; i < nBits; i++) begin
      cur      = mosiQ[i / 8];
      spi_mosi = cur[7 - (i % 8)];
      repeat (8) @(negedge clk);
      shiftIn = {shiftIn[6:0], spi_miso};
      spi_sck = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 4 && i == 7) availFirst = rx_data_avail;
      end
      spi_sck = 1'b0;
      if (i % 8 == 7) misoQ.push_back(shiftIn);
    end
    repeat (8) @(negedge clk);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Run a frame and compare what came back with the model's view of the FIFOs
  task automatic runFrame(input int nBits);
    int nFull;
    logic [7:0] expByte;
    nFull = nBits / 8;
    applyStimulus(nBits);
    checkOutput("busyInFrame", busyMid, 1'b1);
    checkOutput("misoCount", misoQ.size(), nFull);
    for (int k = 0; k <= nFull; k++) begin
      expByte = modelLoad();
      if (k == 0) begin
        checkOutput("misoFirstBit", misoEarly, expByte[7]);
        if (holdWr) begin
          modelTxPush(holdByte);
          checkOutput("txFullHeld", holdFull, 1'b1);
        end
      end
      if (k < nFull && k < misoQ.size()) checkOutput("misoByte", misoQ[k], expByte);
    end
    holdWr = 1'b0;
    for (int k = 0; k < nFull; k++) modelRxPush(mosiQ[k]);
    if (nFull > 0) checkOutput("rxAvailLatency", availFirst, 1'b1);
    checkOutput("busyAfter", busy, 1'b0);
    checkOutput("misoDeselected", spi_miso, 1'b0);
    checkOutput("txFull", tx_full, txModel.size() == FIFO_DEPTH);
    checkOutput("rxAvail", rx_data_avail, rxModel.size() != 0);
    checkStatus();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Miso"}, spi_miso, 1'b0);
    checkOutput({tag, "TxFull"}, tx_full, 1'b0);
    checkOutput({tag, "RxAvail"}, rx_data_avail, 1'b0);
    checkOutput({tag, "RxDout"}, rx_dout, 8'h00);
    checkOutput({tag, "Busy"}, busy, 1'b0);
  endtask

  // Directed scenarios followed by randomized frames
  initial begin
    int nBits;
    int nBytes;
    Rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    tx_wr    = 1'b0;
    tx_din   = 8'h00;
    rx_rd    = 1'b0;
`ifdef SPI_TARGET_STATUS_EN
    status_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkResetOutputs("rstDuring");
    Rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("rstAfter");
    checkStatus();

    // Two queued TX bytes exchanged for two RX bytes in one frame
    pushTx(8'hA5);
    pushTx(8'h3C);
    mosiQ = '{8'h12, 8'h34};
    runFrame(16);
    readRx(2);
    clearStatus();
    checkStatus();

    // Empty TX FIFO sends the idle fill
    mosiQ = '{8'h55};
    runFrame(8);
    readRx(1);
    clearStatus();

    // Five bytes into a four-deep RX FIFO: the fifth is dropped
    mosiQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    runFrame(40);
    readRx(4);
    checkOutput("rxEmptyAfterDrain", rx_data_avail, 1'b0);
    @(negedge clk);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    checkOutput("rxReadEmptyIgnored", rx_data_avail, 1'b0);
    clearStatus();

    // Aborted partial byte, then a clean one
    mosiQ = '{8'hF0};
    runFrame(4);
    mosiQ = '{8'h81};
    runFrame(8);
    readRx(1);
    checkOutput("rxOnlyOneByte", rx_data_avail, 1'b0);
    clearStatus();

    // Full TX FIFO, a write held across the LOAD pop slips in behind the existing bytes
    for (int i = 0; i < FIFO_DEPTH; i++) pushTx(8'($urandom_range(0, 255)));
    checkOutput("txFullAfterFill", tx_full, 1'b1);
    pushTx(8'hEE);
    holdWr   = 1'b1;
    holdByte = 8'h77;
    mosiQ.delete();
    for (int i = 0; i < 5; i++) mosiQ.push_back(8'($urandom_range(0, 255)));
    runFrame(40);
    readRx(4);
    clearStatus();

    // Reset in the middle of a byte with an RX byte and two TX bytes pending
    mosiQ = '{8'h6B};
    runFrame(8);
    pushTx(8'hC3);
    pushTx(8'h5A);
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    #1;
    checkResetOutputs("midRst");
    @(negedge clk);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    repeat (4) @(negedge clk);
    checkResetOutputs("midRstAfter");
    txModel.delete();
    rxModel.delete();
    overrunModel  = 1'b0;
    underrunModel = 1'b0;
    checkStatus();
    mosiQ = '{8'h99};
    runFrame(8);
    readRx(1);
    clearStatus();

    // Randomized traffic
    for (int iter = 0; iter < 10; iter++) begin
      for (int p = $urandom_range(0, 3); p > 0; p--) pushTx(8'($urandom_range(0, 255)));
      nBytes = $urandom_range(1, 3);
      nBits  = nBytes * 8;
      if ($urandom_range(0, 3) == 0) nBits = nBits - $urandom_range(1, 7);
      mosiQ.delete();
      for (int i = 0; i < nBytes; i++) mosiQ.push_back(8'($urandom_range(0, 255)));
      runFrame(nBits);
      readRx($urandom_range(0, rxModel.size()));
      if ($urandom_range(0, 1) == 1) begin
        clearStatus();
        checkStatus();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
